// File: rtl/data_memory_address.sv
// Registered data-bus address decoder: maps a byte address onto two SRAM banks,
// the Control Module input port and the UART1 output port with one cycle of latency.
module data_memory_address #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         RESET,
    input  logic [N-1:0] address,
    input  logic         read,
    input  logic         write,
    output logic         Control_Module,
    output logic         UART1,
    output logic         CE0,
    output logic         CE1,
    output logic         OE0,
    output logic         OE1,
    output logic         WE0,
    output logic         WE1
);

    localparam logic [N-1:0] Sram0Lo = 'h1000_0000;
    localparam logic [N-1:0] Sram0Hi = 'h13FF_FFFF;
    localparam logic [N-1:0] Sram1Lo = 'h1400_0000;
    localparam logic [N-1:0] Sram1Hi = 'h17FF_FFFF;
    localparam logic [N-1:0] CtrlLo  = 'h44E1_0000;
    localparam logic [N-1:0] CtrlHi  = 'h44E1_1FFF;
    localparam logic [N-1:0] UartLo  = 'h4802_2000;
    localparam logic [N-1:0] UartHi  = 'h4802_2FFF;

    typedef enum logic [2:0] {
        RegNone,
        RegSram0,
        RegSram1,
        RegCtrl,
        RegUart
    } region_e;

    region_e region;

    logic ctrl_d, uart_d, ce0_d, ce1_d, oe0_d, oe1_d, we0_d, we1_d;
    logic ctrl_q, uart_q, ce0_q, ce1_q, oe0_q, oe1_q, we0_q, we1_q;

    // An unknown address fails every if-condition and falls through to RegNone.
    always_comb begin
        region = RegNone;
        if (address >= Sram0Lo && address <= Sram0Hi) begin
            region = RegSram0;
        end else if (address >= Sram1Lo && address <= Sram1Hi) begin
            region = RegSram1;
        end else if (address >= CtrlLo && address <= CtrlHi) begin
            region = RegCtrl;
        end else if (address >= UartLo && address <= UartHi) begin
            region = RegUart;
        end
    end

    always_comb begin
        ctrl_d = 1'b0;
        uart_d = 1'b0;
        ce0_d  = 1'b1;
        ce1_d  = 1'b1;
        oe0_d  = 1'b1;
        oe1_d  = 1'b1;
        we0_d  = 1'b1;
        we1_d  = 1'b1;
        unique case (region)
            RegSram0: begin
                ce0_d = 1'b0;
                // Write wins over read, so OE and WE are never low together.
                if (write)     we0_d = 1'b0;
                else if (read) oe0_d = 1'b0;
            end
            RegSram1: begin
                ce1_d = 1'b0;
                if (write)     we1_d = 1'b0;
                else if (read) oe1_d = 1'b0;
            end
            RegCtrl: ctrl_d = 1'b1;
            RegUart: uart_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            ctrl_q <= 1'b0;
            uart_q <= 1'b0;
            ce0_q  <= 1'b1;
            ce1_q  <= 1'b1;
            oe0_q  <= 1'b1;
            oe1_q  <= 1'b1;
            we0_q  <= 1'b1;
            we1_q  <= 1'b1;
        end else begin
            ctrl_q <= ctrl_d;
            uart_q <= uart_d;
            ce0_q  <= ce0_d;
            ce1_q  <= ce1_d;
            oe0_q  <= oe0_d;
            oe1_q  <= oe1_d;
            we0_q  <= we0_d;
            we1_q  <= we1_d;
        end
    end

    assign Control_Module = ctrl_q;
    assign UART1          = uart_q;
    assign CE0            = ce0_q;
    assign CE1            = ce1_q;
    assign OE0            = oe0_q;
    assign OE1            = oe1_q;
    assign WE0            = we0_q;
    assign WE1            = we1_q;

endmodule

// File: tb/tb_data_memory_address.sv
// Directed bench for data_memory_address; outputs packed as
// {Control_Module, UART1, CE0, CE1, OE0, OE1, WE0, WE1}.
module tb_data_memory_address;

    logic        clk = 1'b0;
    logic        RESET;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic        Control_Module, UART1, CE0, CE1, OE0, OE1, WE0, WE1;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    localparam logic [7:0] Idle   = 8'b00_111111;
    localparam logic [7:0] S0Idle = 8'b00_011111;
    localparam logic [7:0] S0Rd   = 8'b00_010111;
    localparam logic [7:0] S0Wr   = 8'b00_011101;
    localparam logic [7:0] S1Idle = 8'b00_101111;
    localparam logic [7:0] S1Rd   = 8'b00_101011;
    localparam logic [7:0] S1Wr   = 8'b00_101110;
    localparam logic [7:0] Ctrl   = 8'b10_111111;
    localparam logic [7:0] Uart   = 8'b01_111111;

    data_memory_address #(.N(32)) dut (
        .clk            (clk),
        .RESET          (RESET),
        .address        (address),
        .read           (read),
        .write          (write),
        .Control_Module (Control_Module),
        .UART1          (UART1),
        .CE0            (CE0),
        .CE1            (CE1),
        .OE0            (OE0),
        .OE1            (OE1),
        .WE0            (WE0),
        .WE1            (WE1)
    );

    always #5 clk = ~clk;

    // Apply inputs, take one rising edge, then compare 1 time unit later.
    task automatic step(input logic [31:0] a, input logic rd, input logic wr, input logic rst,
                        input logic [7:0] exp, input string tag);
        logic [7:0] obs;
        address = a;
        read    = rd;
        write   = wr;
        RESET   = rst;
        @(posedge clk);
        #1;
        obs = {Control_Module, UART1, CE0, CE1, OE0, OE1, WE0, WE1};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        address = '0;
        read    = 1'b0;
        write   = 1'b0;
        RESET   = 1'b1;
        @(negedge clk);

        step(32'h1000_08AD, 1'b0, 1'b0, 1'b1, Idle, "reset_edge1");
        step(32'h1000_08AD, 1'b0, 1'b0, 1'b1, Idle, "reset_edge2");

        step(32'h1000_08AD, 1'b0, 1'b0, 1'b0, S0Idle, "sram0_idle");
        step(32'h1000_08AD, 1'b1, 1'b0, 1'b0, S0Rd,   "sram0_read");
        step(32'h1000_08AD, 1'b0, 1'b1, 1'b0, S0Wr,   "sram0_write");
        step(32'h1000_08AD, 1'b0, 1'b0, 1'b0, S0Idle, "sram0_write_off");

        step(32'h1400_0F32, 1'b0, 1'b0, 1'b0, S1Idle, "sram1_idle");
        step(32'h1400_0F32, 1'b1, 1'b0, 1'b0, S1Rd,   "sram1_read");
        step(32'h1400_0F32, 1'b0, 1'b1, 1'b0, S1Wr,   "sram1_write");
        step(32'h1400_0F32, 1'b1, 1'b1, 1'b0, S1Wr,   "sram1_rd_wr");
        step(32'h1000_08AD, 1'b1, 1'b1, 1'b0, S0Wr,   "sram0_rd_wr");

        step(32'h44E1_0ABC, 1'b1, 1'b0, 1'b0, Ctrl, "ctrl_mod");
        step(32'h4802_2C58, 1'b0, 1'b1, 1'b0, Uart, "uart1");
        step(32'h4802_2C58, 1'b0, 1'b0, 1'b0, Uart, "uart1_idle");

        step(32'h2000_0FFA, 1'b1, 1'b0, 1'b0, Idle, "unmapped_2000");
        step(32'h44E1_28AD, 1'b0, 1'b1, 1'b0, Idle, "unmapped_44e1");
        step(32'h4802_3BBB, 1'b1, 1'b1, 1'b0, Idle, "unmapped_4802");

        step(32'h13FF_FFFF, 1'b1, 1'b0, 1'b0, S0Rd, "bound_sram0_hi");
        step(32'h1400_0000, 1'b1, 1'b0, 1'b0, S1Rd, "bound_sram1_lo");
        step(32'h17FF_FFFF, 1'b0, 1'b1, 1'b0, S1Wr, "bound_sram1_hi");
        step(32'h0FFF_FFFF, 1'b1, 1'b0, 1'b0, Idle, "bound_below_sram0");
        step(32'h1800_0000, 1'b0, 1'b1, 1'b0, Idle, "bound_above_sram1");
        step(32'h44E1_0000, 1'b0, 1'b0, 1'b0, Ctrl, "bound_ctrl_lo");
        step(32'h44E1_1FFF, 1'b0, 1'b0, 1'b0, Ctrl, "bound_ctrl_hi");
        step(32'h44E1_2000, 1'b0, 1'b0, 1'b0, Idle, "bound_above_ctrl");
        step(32'h4802_1FFF, 1'b0, 1'b0, 1'b0, Idle, "bound_below_uart");
        step(32'h4802_2000, 1'b0, 1'b0, 1'b0, Uart, "bound_uart_lo");
        step(32'h4802_2FFF, 1'b0, 1'b0, 1'b0, Uart, "bound_uart_hi");

        step(32'h1000_08AD, 1'b0, 1'b1, 1'b0, S0Wr, "pre_reset_write");
        step(32'h1000_08AD, 1'b0, 1'b1, 1'b1, Idle, "reset_mid_write");
        step(32'h1000_08AD, 1'b0, 1'b1, 1'b0, S0Wr, "resume_after_reset");
        step(32'h44E1_0ABC, 1'b0, 1'b0, 1'b1, Idle, "reset_over_ctrl");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
